instr_fetch_dual: RTL and testbench

//  Dual-issue instruction fetch unit for the superscalar core. Requester side of the instruction-memory read interface.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/instr_fetch_dual.sv | 105 ++++++++++
 tb/tb_instr_fetch_dual.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch unit.
package fetch_pkg;

   localparam logic [31:0] FAULT_WORD = 32'hFFFFFFFF;
   localparam logic [31:0] NOP_WORD   = 32'h38000000;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// 2-write / 2-read circular fetch queue; head and next entry are read combinationally.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int CW     = $clog2(QDEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [1:0]    enq,
   input  entry_t        wdata0,
   input  entry_t        wdata1,
   input  logic [1:0]    take,
   output logic [CW-1:0] count,
   output logic          rvalid0,
   output logic          rvalid1,
   output entry_t        rdata0,
   output entry_t        rdata1
);

   localparam int PW = $clog2(QDEPTH);

   entry_t        mem [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] take_eff;

   // Decode may ask for more than is queued; clamp silently.
   assign take_eff = (CW'(take) > count) ? count : CW'(take);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(enq);
         rd_ptr <= rd_ptr + PW'(take_eff);
         count  <= count + CW'(enq) - take_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && enq != 2'd0) mem[wr_ptr] <= wdata0;
      if (!flush && enq == 2'd2) mem[wr_ptr + PW'(1)] <= wdata1;
   end

   assign rvalid0 = (count >= CW'(1));
   assign rvalid1 = (count >= CW'(2));
   assign rdata0  = rvalid0 ? mem[rd_ptr] : '0;
   assign rdata1  = rvalid1 ? mem[rd_ptr + PW'(1)] : '0;

endmodule

// File: rtl/instr_fetch_dual.sv
// Dual-issue fetch: PC register, BOOT/RUN/HALT control and two-word fetch into the queue.
module instr_fetch_dual
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00400000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ReadMem_1,
   output logic        ReadMem_2,
   output logic [31:0] Dir_Instru_1,
   output logic [31:0] Dir_Instru_2,
   input  logic [31:0] Dato_Instru_1,
   input  logic [31:0] Dato_Instru_2,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [1:0]  dec_take,
   output logic        inst0_valid,
   output logic [31:0] inst0,
   output logic [31:0] inst0_pc,
   output logic        inst1_valid,
   output logic [31:0] inst1,
   output logic [31:0] inst1_pc,
   output logic        fetch_fault
);

   localparam int CW = $clog2(QDEPTH) + 1;

   state_t        state;
   logic [31:0]   pc;
   logic [CW-1:0] count;
   logic          fetch_en;
   logic          fault1;
   logic          fault2;
   logic [1:0]    enq;
   logic [1:0]    take;
   entry_t        wdata0, wdata1, rdata0, rdata1;

   // Space check uses the registered count so fetch never depends on decode's take.
   assign fetch_en = (state == RUN) && !redirect_valid && (count <= CW'(QDEPTH - 2));
   assign fault1   = (Dato_Instru_1 == FAULT_WORD);
   assign fault2   = (Dato_Instru_2 == FAULT_WORD);

   assign ReadMem_1    = ~fetch_en;
   assign ReadMem_2    = ~fetch_en;
   assign Dir_Instru_1 = pc;
   assign Dir_Instru_2 = pc + 32'd4;
   assign fetch_fault  = (state == HALT);
   assign take         = redirect_valid ? 2'd0 : dec_take;

   always_comb begin
      enq = 2'd0;
      if (fetch_en) enq = fault1 ? 2'd0 : (fault2 ? 2'd1 : 2'd2);
   end

   assign wdata0 = '{pc: pc,          instr: Dato_Instru_1};
   assign wdata1 = '{pc: pc + 32'd4,  instr: Dato_Instru_2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else if (redirect_valid) begin
         state <= RUN;
         pc    <= redirect_pc & ~32'd3;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN: if (fetch_en) begin
               if (fault1) begin
                  state <= HALT;
               end else if (fault2) begin
                  state <= HALT;
                  pc    <= pc + 32'd4;
               end else begin
                  pc    <= pc + 32'd8;
               end
            end
            default: ;
         endcase
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect_valid),
      .enq     (enq),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .take    (take),
      .count   (count),
      .rvalid0 (inst0_valid),
      .rvalid1 (inst1_valid),
      .rdata0  (rdata0),
      .rdata1  (rdata1)
   );

   assign inst0    = rdata0.instr;
   assign inst0_pc = rdata0.pc;
   assign inst1    = rdata1.instr;
   assign inst1_pc = rdata1.pc;

endmodule

// File: tb/tb_instr_fetch_dual.sv
// Directed bench for instr_fetch_dual with a combinational instruction-memory model.
module tb_instr_fetch_dual;

   logic        clk = 1'b0;
   logic        rst;
   logic        ReadMem_1, ReadMem_2;
   logic [31:0] Dir_Instru_1, Dir_Instru_2;
   logic [31:0] Dato_Instru_1, Dato_Instru_2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  dec_take;
   logic        inst0_valid, inst1_valid, fetch_fault;
   logic [31:0] inst0, inst0_pc, inst1, inst1_pc;

   int checks   = 0;
   int failures = 0;

   instr_fetch_dual dut (
      .clk(clk), .rst(rst),
      .ReadMem_1(ReadMem_1), .ReadMem_2(ReadMem_2),
      .Dir_Instru_1(Dir_Instru_1), .Dir_Instru_2(Dir_Instru_2),
      .Dato_Instru_1(Dato_Instru_1), .Dato_Instru_2(Dato_Instru_2),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_take(dec_take),
      .inst0_valid(inst0_valid), .inst0(inst0), .inst0_pc(inst0_pc),
      .inst1_valid(inst1_valid), .inst1(inst1), .inst1_pc(inst1_pc),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h00400000: return 32'h38000000;
         32'h00400004: return 32'h8D710001;
         32'h00400080: return 32'h8232A820;
         32'h00400084: return 32'h852AB021;
         32'h00400088: return 32'hFFFFFFFF;
         default:      return 32'h10000000 | a;
      endcase
   endfunction

   assign Dato_Instru_1 = mem_word(Dir_Instru_1);
   assign Dato_Instru_2 = mem_word(Dir_Instru_2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_take = 2'd0;
      cyc(); cyc();
      chk("rst_rm1", ReadMem_1, 1);
      chk("rst_rm2", ReadMem_2, 1);
      chk("rst_dir1", Dir_Instru_1, 32'h00400000);
      chk("rst_dir2", Dir_Instru_2, 32'h00400004);
      chk("rst_v0", inst0_valid, 0);
      chk("rst_v1", inst1_valid, 0);
      chk("rst_i0", inst0, 0);
      chk("rst_pc0", inst0_pc, 0);
      chk("rst_fault", fetch_fault, 0);

      // BOOT cycle
      rst = 1'b0; #1;
      chk("boot_rm", ReadMem_1, 1);
      cyc(); #1;
      chk("run_rm1", ReadMem_1, 0);
      chk("run_rm2", ReadMem_2, 0);
      chk("run_dir1", Dir_Instru_1, 32'h00400000);
      chk("run_dir2", Dir_Instru_2, 32'h00400004);
      cyc(); #1;
      chk("f1_i0", inst0, 32'h38000000);
      chk("f1_pc0", inst0_pc, 32'h00400000);
      chk("f1_i1", inst1, 32'h8D710001);
      chk("f1_pc1", inst1_pc, 32'h00400004);
      chk("f1_rm", ReadMem_1, 0);
      cyc(); #1;
      chk("full_rm", ReadMem_1, 1);
      chk("full_dir1", Dir_Instru_1, 32'h00400010);
      chk("full_pc0", inst0_pc, 32'h00400000);

      // Single-take drain with refills: strict program order on inst0.
      for (int i = 0; i < 7; i++) begin
         if (i > 0) cyc();
         dec_take = 2'd1; #1;
         chk("seq_v0", inst0_valid, 1);
         chk("seq_pc0", inst0_pc, 32'h00400000 + 32'(4 * i));
         chk("seq_i0", inst0, mem_word(32'h00400000 + 32'(4 * i)));
      end

      // Redirect with 3 entries queued; low PC bits dropped, dec_take ignored.
      cyc();
      dec_take = 2'd2; redirect_valid = 1'b1; redirect_pc = 32'h00400082; #1;
      chk("rd_pre_pc0", inst0_pc, 32'h0040001C);
      chk("rd_pre_rm", ReadMem_1, 1);
      cyc();
      redirect_valid = 1'b0; dec_take = 2'd0; #1;
      chk("rd_v0", inst0_valid, 0);
      chk("rd_v1", inst1_valid, 0);
      chk("rd_dir1", Dir_Instru_1, 32'h00400080);
      chk("rd_rm", ReadMem_1, 0);
      cyc();
      dec_take = 2'd3; #1;
      chk("rd_i0", inst0, 32'h8232A820);
      chk("rd_i1", inst1, 32'h852AB021);
      chk("rd_pc1", inst1_pc, 32'h00400084);
      chk("p1f_dir1", Dir_Instru_1, 32'h00400088);

      // Port-1 fault at 0x88: nothing enqueued, PC holds; oversized take clamps to 2.
      cyc();
      dec_take = 2'd0; #1;
      chk("p1f_fault", fetch_fault, 1);
      chk("p1f_rm", ReadMem_1, 1);
      chk("p1f_v0", inst0_valid, 0);
      chk("p1f_dir1", Dir_Instru_1, 32'h00400088);
      redirect_valid = 1'b1; redirect_pc = 32'h00400084; #1;
      cyc();
      redirect_valid = 1'b0; #1;
      chk("p2f_pre_fault", fetch_fault, 0);
      chk("p2f_pre_rm", ReadMem_2, 0);
      chk("p2f_pre_dir2", Dir_Instru_2, 32'h00400088);

      // Port-2 fault: only word 1 enqueued, PC advances by 4.
      cyc(); #1;
      chk("p2f_fault", fetch_fault, 1);
      chk("p2f_i0", inst0, 32'h852AB021);
      chk("p2f_pc0", inst0_pc, 32'h00400084);
      chk("p2f_v1", inst1_valid, 0);
      chk("p2f_rm", ReadMem_1, 1);
      chk("p2f_dir1", Dir_Instru_1, 32'h00400088);
      cyc(); #1;
      chk("halt_hold", fetch_fault, 1);
      chk("halt_v0", inst0_valid, 1);
      redirect_valid = 1'b1; redirect_pc = 32'h00400000; #1;
      cyc();
      redirect_valid = 1'b0; #1;
      chk("res_fault", fetch_fault, 0);
      chk("res_v0", inst0_valid, 0);
      chk("res_rm", ReadMem_1, 0);
      chk("res_dir1", Dir_Instru_1, 32'h00400000);
      cyc();
      dec_take = 2'd1; #1;
      chk("res_i0", inst0, 32'h38000000);
      chk("res_i1", inst1, 32'h8D710001);
      cyc();
      dec_take = 2'd0; #1;
      chk("pre_rst_pc0", inst0_pc, 32'h00400004);
      chk("pre_rst_v1", inst1_valid, 1);

      // Async reset mid-cycle with 3 entries queued.
      rst = 1'b1; #1;
      chk("arst_v0", inst0_valid, 0);
      chk("arst_v1", inst1_valid, 0);
      chk("arst_rm", ReadMem_1, 1);
      chk("arst_dir1", Dir_Instru_1, 32'h00400000);
      chk("arst_dir2", Dir_Instru_2, 32'h00400004);
      cyc();

      // Address wrap at the top of memory, redirect taken during BOOT.
      rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF; #1;
      chk("wrap_boot_rm", ReadMem_1, 1);
      cyc();
      redirect_valid = 1'b0; #1;
      chk("wrap_dir1", Dir_Instru_1, 32'hFFFFFFFC);
      chk("wrap_dir2", Dir_Instru_2, 32'h00000000);
      chk("wrap_rm", ReadMem_2, 0);
      cyc(); #1;
      chk("wrap_pc0", inst0_pc, 32'hFFFFFFFC);
      chk("wrap_pc1", inst1_pc, 32'h00000000);
      chk("wrap_i1", inst1, 32'h10000000);
      chk("wrap_dir_next", Dir_Instru_1, 32'h00000004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
